// File: rtl/alu_share_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arb_if
//  Description : Requester, ALU-side and response signals of the shared-ALU
//                arbiter. The slave view belongs to the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_share_arb_if #(
    parameter int WIDTH = 32
) ();
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [3:0]       aluc0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [3:0]       aluc1;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_aluc;
    logic [WIDTH-1:0] alu_s;
    logic             alu_z;
    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_s;
    logic             rsp_z;
    logic             rsp_ready;
    logic             busy;

    modport slave (
        input  req0, a0, b0, aluc0, req1, a1, b1, aluc1, alu_s, alu_z, rsp_ready,
        output gnt0, gnt1, alu_a, alu_b, alu_aluc, rsp_valid, rsp_id, rsp_s, rsp_z, busy
    );

    modport master (
        output req0, a0, b0, aluc0, req1, a1, b1, aluc1, alu_s, alu_z, rsp_ready,
        input  gnt0, gnt1, alu_a, alu_b, alu_aluc, rsp_valid, rsp_id, rsp_s, rsp_z, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arb
//  Description : Two-requester arbiter in front of one combinational ALU.
//                Round-robin by default; define ALU_SHARE_FIXED_PRIO_EN for
//                fixed priority to requester 0.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_share_arb #(
    parameter int WIDTH = 32
) (
    input  wire logic      clock,
    input  wire logic      resetn,
    alu_share_arb_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last;
    logic             r_busy;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_aluc;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_s;
    logic             r_rsp_z;

    logic             w_any;
    logic             w_win;
    logic             w_gnt0;
    logic             w_gnt1;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [3:0]       w_aluc;

    always_comb begin
        w_any = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
            w_win = 1'b0;
`else
            // On a tie the requester that did not win last time goes next
            w_win = ~r_last;
`endif
        end else begin
            w_win = bus.req1;
        end
        w_gnt0 = (r_state == S_IDLE) && w_any && !w_win;
        w_gnt1 = (r_state == S_IDLE) && w_any &&  w_win;
        w_a    = w_win ? bus.a1    : bus.a0;
        w_b    = w_win ? bus.b1    : bus.b0;
        w_aluc = w_win ? bus.aluc1 : bus.aluc0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_busy      <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_aluc  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_s     <= '0;
            r_rsp_z     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_alu_a    <= w_a;
                        r_alu_b    <= w_b;
                        r_alu_aluc <= w_aluc;
                        r_rsp_id   <= w_win;
                        r_last     <= w_win;
                        r_busy     <= 1'b1;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_s     <= bus.alu_s;
                    r_rsp_z     <= bus.alu_z;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_aluc  = r_alu_aluc;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_s     = r_rsp_s;
    assign bus.rsp_z     = r_rsp_z;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arb
//  Description : Scoreboard bench for alu_share_arb with a behavioural ALU.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_share_arb;
    localparam int W = 32;
`ifdef ALU_SHARE_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        logic         id;
        logic [W-1:0] s;
        logic         z;
    } rsp_t;

    logic clock;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    alu_share_arb_if #(.WIDTH(W)) bus ();

    alu_share_arb #(.WIDTH(W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] c);
        case (c)
            4'b0000: return a + b;
            4'b0100: return a - b;
            4'b0001: return a & b;
            4'b0101: return a | b;
            4'b0010: return a ^ b;
            4'b0110: return b << 16;
            4'b0011: return b << a[4:0];
            4'b0111: return b >> a[4:0];
            4'b1111: return $signed(b) >>> a[4:0];
            default: return '0;
        endcase
    endfunction

    // Environment ALU that the arbiter drives
    assign bus.alu_s = alu_ref(bus.alu_a, bus.alu_b, bus.alu_aluc);
    assign bus.alu_z = (bus.alu_s == '0);

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    rsp_t sb[$];
    logic glog[$];
    bit   m_busy = 1'b0;
    bit   m_last = 1'b1;
    int   g_cyc  = 0;

    always @(negedge clock) begin
        bit   exp_g0, exp_g1, w, exp_v;
        rsp_t e;
        if (!resetn) begin
            sb.delete();
            m_busy = 1'b0;
            m_last = 1'b1;
        end else begin
            exp_g0 = 1'b0;
            exp_g1 = 1'b0;
            w      = 1'b0;
            if (!m_busy && (bus.req0 || bus.req1)) begin
                if (bus.req0 && bus.req1) w = FIXED ? 1'b0 : !m_last;
                else                      w = bus.req1;
                exp_g0 = !w;
                exp_g1 = w;
            end
            check("gnt", {62'd0, bus.gnt1, bus.gnt0}, {62'd0, exp_g1, exp_g0});
            if (bus.gnt0 || bus.gnt1) glog.push_back(bus.gnt1);
            check("busy", {63'd0, bus.busy}, {63'd0, m_busy});
            exp_v = m_busy && (cyc >= g_cyc + 2);
            check("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, exp_v});
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    check("rsp_id", {63'd0, bus.rsp_id}, {63'd0, sb[0].id});
                    check("rsp_s",  {32'd0, bus.rsp_s},  {32'd0, sb[0].s});
                    check("rsp_z",  {63'd0, bus.rsp_z},  {63'd0, sb[0].z});
                end
            end
            if (exp_v && bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() > 0) void'(sb.pop_front());
                m_busy = 1'b0;
            end
            if (exp_g0 || exp_g1) begin
                e.id = w;
                e.s  = w ? alu_ref(bus.a1, bus.b1, bus.aluc1) : alu_ref(bus.a0, bus.b0, bus.aluc0);
                e.z  = (e.s == '0);
                sb.push_back(e);
                m_busy = 1'b1;
                m_last = w;
                g_cyc  = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] c);
        int cnt = 0;
        bit got = 1'b0;
        if (id == 0) begin bus.a0 = a; bus.b0 = b; bus.aluc0 = c; bus.req0 = 1'b1; end
        else         begin bus.a1 = a; bus.b1 = b; bus.aluc1 = c; bus.req1 = 1'b1; end
        while (!got && cnt < 300) begin
            @(negedge clock);
            cnt++;
            got = (id == 0) ? bus.gnt0 : bus.gnt1;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_timeout: requester %0d not granted after %0d cycles", id, cnt);
        end
        @(posedge clock);
        #1;
        if (id == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    endtask

    task automatic requester(input int id, input int n, input int maxgap);
        logic [W-1:0] a, b;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, maxgap)) begin @(posedge clock); #1; end
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            issue(id, a, b, 4'($urandom_range(0, 15)));
        end
    endtask

    task automatic wait_idle();
        int cnt = 0;
        do begin @(negedge clock); cnt++; end while ((bus.busy || bus.rsp_valid) && cnt < 100);
        if (bus.busy || bus.rsp_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b rsp_valid=%0b", bus.busy, bus.rsp_valid);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  base;
        bit  done = 1'b0;
        resetn = 1'b0;
        bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.aluc0 = '0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.aluc1 = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_alu_a",    {32'd0, bus.alu_a}, 64'd0);
        check("rst_alu_b",    {32'd0, bus.alu_b}, 64'd0);
        check("rst_alu_aluc", {60'd0, bus.alu_aluc}, 64'd0);
        check("rst_rsp",      {30'd0, bus.rsp_s, bus.rsp_z, bus.rsp_id}, 64'd0);
        check("rst_flags",    {60'd0, bus.rsp_valid, bus.busy, bus.gnt1, bus.gnt0}, 64'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;

        // single ADD request
        issue(0, 5, 7, 4'b0000);
        wait_idle();

        // tie after reset: SUB from 0 first, then OR from 1, then tie again
        fork
            issue(0, 9, 9, 4'b0100);
            issue(1, 32'hF0, 32'h0F, 4'b0101);
        join
        wait_idle();
        fork
            issue(0, 3, 4, 4'b0000);
            issue(1, 6, 2, 4'b0100);
        join
        wait_idle();

        // backpressure while requester 1 waits
        bus.rsp_ready = 1'b0;
        fork
            issue(0, 32'h1234, 32'h1, 4'b0000);
            begin @(posedge clock); #1; issue(1, 32'hAA, 32'h55, 4'b0010); end
            begin
                int cnt = 0;
                while (!bus.rsp_valid && cnt < 50) begin @(negedge clock); cnt++; end
                repeat (5) @(posedge clock);
                #1 bus.rsp_ready = 1'b1;
            end
        join
        wait_idle();

        // shift passthrough
        issue(1, 4, 1, 4'b0011);
        wait_idle();

        // reset during EXEC drops the operation
        issue(0, 32'hDEAD, 32'h1, 4'b0000);
        #2 resetn = 1'b0;
        #1;
        check("midrst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("midrst_busy",      {63'd0, bus.busy}, 64'd0);
        check("midrst_alu_a",     {32'd0, bus.alu_a}, 64'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        fork
            issue(0, 1, 1, 4'b0000);
            issue(1, 2, 2, 4'b0000);
        join
        wait_idle();

        // both requesters held for six operations each
        base = glog.size();
        fork
            requester(0, 6, 0);
            requester(1, 6, 0);
        join
        wait_idle();
        for (int k = 0; k < 6; k++) begin
            if (base + k < glog.size())
                check($sformatf("prio_grant%0d", k), {63'd0, glog[base + k]},
                      {63'd0, FIXED ? 1'b0 : 1'(k % 2)});
            else
                check($sformatf("prio_grant%0d_missing", k), 64'd1, 64'd0);
        end

        // randomized traffic with random backpressure
        fork
            begin
                fork
                    requester(0, 40, 3);
                    requester(1, 40, 3);
                join
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock);
                    #1 bus.rsp_ready = 1'($urandom_range(0, 1));
                end
                bus.rsp_ready = 1'b1;
            end
        join
        wait_idle();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational ALU between two requesters (e.g. the integer execute path and an address/branch helper unit).
- Arbitrates between requests, latches the winner's operands, and drives the ALU for one cycle.
- Captures the result and zero flag, then holds the response until it is accepted.
- Sits between the requesters and the existing `alu`; the ALU's opcode encoding is unchanged.

Parameters:
- WIDTH, 32, operand and result width; must match the ALU datapath.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 request; held until gnt0.
- a0  in  WIDTH  requester 0 operand a.
- b0  in  WIDTH  requester 0 operand b.
- aluc0  in  4  requester 0 ALU opcode.
- req1  in  1  requester 1 request; held until gnt1.
- a1  in  WIDTH  requester 1 operand a.
- b1  in  WIDTH  requester 1 operand b.
- aluc1  in  4  requester 1 ALU opcode.
- gnt0  out  1  one-cycle accept pulse to requester 0.
- gnt1  out  1  one-cycle accept pulse to requester 1.
- alu_a  out  WIDTH  to ALU a; registered.
- alu_b  out  WIDTH  to ALU b; registered.
- alu_aluc  out  4  to ALU aluc; registered.
- alu_s  in  WIDTH  ALU result.
- alu_z  in  1  ALU zero flag.
- rsp_valid  out  1  response available.
- rsp_id  out  1  requester that owns the response.
- rsp_s  out  WIDTH  captured result.
- rsp_z  out  1  captured zero flag.
- rsp_ready  in  1  response consumer accepts.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock, clock, with resetn asynchronous and active-low.
- Reset values: state=IDLE. alu_a, alu_b, alu_aluc, rsp_s, rsp_z, rsp_id, rsp_valid and busy are all 0. last=1, so requester 0 wins the first tie. gnt0/gnt1 are 0.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - With no request, stay in IDLE.
  - Otherwise select a winner: a single requester wins outright; if both request, the winner is the one that is not `last`.
  - gnt_winner is asserted combinationally during this IDLE cycle only.
  - On the clock edge, load alu_a/alu_b/alu_aluc from the winner's operands, set rsp_id=winner, set last=winner, and go to EXEC.
  - The requester drops req, or presents a new operation, after the edge where it saw its grant.
- EXEC: the ALU settles from the registered inputs. On the edge, rsp_s<=alu_s, rsp_z<=alu_z, rsp_valid<=1, and go to RESP. No grants in this state.
- RESP:
  - rsp_valid=1; rsp_s, rsp_z and rsp_id are held stable.
  - If rsp_ready=1, clear rsp_valid on the edge and go to IDLE.
  - If rsp_ready=0, hold indefinitely. No grants in this state.
- Latency: grant in cycle T; rsp_valid is high from cycle T+2. A request can be accepted no earlier than cycle T+3, so peak throughput is one operation per 3 cycles.
- alu_* outputs hold their last operation after completion; they are not cleared.
- Opcodes are passed through untouched. Undefined codes produce whatever the ALU returns (s=0, z=1); this is not an error.
- Requests arriving in EXEC or RESP wait; they are not lost as long as req is held.
- Reset mid-operation: all registers return to their reset values immediately, the in-flight operation is dropped, and no response is produced.
- busy = (state != IDLE).

Optional Feature:
- Macro: ALU_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority. Requester 0 always wins when both request. `last` is still updated but ignored for selection, so requester 1 can starve.
- Undefined (default): round-robin using `last`, as described in Behaviour.

Test Plan:
- Single request: req0=1, a0=5, b0=7, aluc0=4'b0000 -> gnt0 pulse in cycle T; rsp_valid high in T+2 with rsp_s=12, rsp_z=0, rsp_id=0; rsp_ready=1 -> IDLE in T+3.
- Tie after reset, round-robin, both requests held:
  - First operation: req0 SUB with a0=9, b0=9 -> gnt0 first; rsp_s=0, rsp_z=1, rsp_id=0.
  - Second operation: req1 OR with a1=32'hF0, b1=32'h0F -> gnt1 next; rsp_s=32'hFF, rsp_id=1.
  - Third operation: tie again -> gnt0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_s and rsp_id stable; busy=1; no gnt pulses while req1 is pending. Raising rsp_ready -> IDLE, then gnt1.
- Shift passthrough: req1 with aluc1=4'b0011, a1=4, b1=1 -> rsp_s=16, rsp_z=0, rsp_id=1.
- Reset mid-operation: drop resetn during EXEC -> rsp_valid=0, busy=0 and alu_a=0 immediately. After release: IDLE, no response, and req0 is granted first on a tie.
- Priority macro, both requests held for 6 operations:
  - With ALU_SHARE_FIXED_PRIO_EN defined: all grants go to requester 0.
  - Without it: grants alternate 0, 1, 0, 1, 0, 1.
